alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter_pkg.sv | 37 +++
 rtl/alu_req_arbiter_if.sv | 41 ++++
 rtl/alu_req_arbiter_rr_grant.sv | 21 ++
 rtl/alu_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode values,
// instruction-word field positions and the control FSM state set.
package alu_req_arbiter_pkg;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = 8;

    // Instruction word layout: [11:8] opcode, [7:4] operand A, [3:0] operand B
    localparam int unsigned OP_MSB = 11;
    localparam int unsigned OP_LSB = 8;
    localparam int unsigned A_MSB  = 7;
    localparam int unsigned A_LSB  = 4;
    localparam int unsigned B_MSB  = 3;
    localparam int unsigned B_LSB  = 0;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, response and datapath bus of the ALU arbiter.
// master: the arbiter side; slave: requesters, response consumer, datapath.
interface alu_req_arbiter_if;
    import alu_req_arbiter_pkg::*;

    logic              req0_valid;
    logic [WORD_W-1:0] req0_word;
    logic              req0_ready;
    logic              req1_valid;
    logic [WORD_W-1:0] req1_word;
    logic              req1_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic [WORD_W-1:0] dp_data;
    logic              ldA;
    logic              ldB;
    logic              aCmp;
    logic              aAdd;
    logic              aSub;
    logic              aDiv;
    logic              aMul;
    logic [DATA_W-1:0] dp_result;

    modport master (
        input  req0_valid, req0_word, req1_valid, req1_word, rsp_ready, dp_result,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               dp_data, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul
    );

    modport slave (
        output req0_valid, req0_word, req1_valid, req1_word, rsp_ready, dp_result,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               dp_data, ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul
    );

endinterface

// File: rtl/alu_req_arbiter_rr_grant.sv
// Two-way round-robin grant: the pointer names the favoured requester and
// only matters when both are valid.
module alu_rr_grant (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_ptr,
    output logic o_grant,
    output logic o_id
);

    // Pick the favoured requester on contention, otherwise whoever is valid
    always_comb begin
        o_grant = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_id = i_ptr;
        end else begin
            o_id = i_valid1;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sequencing two requesters' instruction words through a
// multi-cycle ALU datapath (load A, load B, execute, wait, respond).
// Optional macro ALU_ARB_DIVZERO_EN: reject DIV with operand B == 0 as an
// error response (rsp_data 8'hFF) instead of issuing it.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_req_arbiter_if.master  bus
);

    state_e             r_state;
    logic               r_rr_ptr;
    logic [3:0]         r_op;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_err;
    logic [WORD_W-1:0]  r_dp_data;
    logic               r_ldA;
    logic               r_ldB;
    logic               r_aCmp;
    logic               r_aAdd;
    logic               r_aSub;
    logic               r_aDiv;
    logic               r_aMul;

    logic               w_grant;
    logic               w_gnt_id;
    logic [WORD_W-1:0]  w_sel_word;
    logic [3:0]         w_sel_op;
    logic               w_divzero;
    logic               w_issue;
    logic [DATA_W-1:0]  w_err_data;
    logic [WAIT_W-1:0]  w_wait_load;
    logic               w_accept;

    alu_rr_grant u_rr_grant (
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .i_ptr    (r_rr_ptr),
        .o_grant  (w_grant),
        .o_id     (w_gnt_id)
    );

    // Decode the granted word: issue legality, error payload, wait length
    always_comb begin
        w_sel_word = w_gnt_id ? bus.req1_word : bus.req0_word;
        w_sel_op   = w_sel_word[OP_MSB:OP_LSB];
`ifdef ALU_ARB_DIVZERO_EN
        w_divzero  = (w_sel_op == OP_DIV) && (w_sel_word[B_MSB:B_LSB] == 4'h0);
`else
        w_divzero  = 1'b0;
`endif
        w_issue    = is_legal_op(w_sel_op) && !w_divzero;
        w_err_data = w_divzero ? 8'hFF : 8'h00;
        w_accept   = reset && (r_state == ST_IDLE) && w_grant;
        case (r_op)
            OP_MUL:  w_wait_load = WAIT_W'(MUL_CYCLES - 1);
            OP_DIV:  w_wait_load = WAIT_W'(DIV_CYCLES - 1);
            default: w_wait_load = '0;
        endcase
    end

    // Control FSM; every bus output except the ready pulses is a register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 1'b0;
            r_op        <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_dp_data   <= '0;
            r_ldA       <= 1'b0;
            r_ldB       <= 1'b0;
            r_aCmp      <= 1'b0;
            r_aAdd      <= 1'b0;
            r_aSub      <= 1'b0;
            r_aDiv      <= 1'b0;
            r_aMul      <= 1'b0;
        end else begin
            r_ldA  <= 1'b0;
            r_ldB  <= 1'b0;
            r_aCmp <= 1'b0;
            r_aAdd <= 1'b0;
            r_aSub <= 1'b0;
            r_aDiv <= 1'b0;
            r_aMul <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_op     <= w_sel_op;
                        r_rsp_id <= w_gnt_id;
                        r_rr_ptr <= ~w_gnt_id;
                        if (w_issue) begin
                            r_state   <= ST_LOAD_A;
                            r_ldA     <= 1'b1;
                            r_dp_data <= w_sel_word;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= w_err_data;
                        end
                    end
                end
                ST_LOAD_A: begin
                    r_state <= ST_LOAD_B;
                    r_ldB   <= 1'b1;
                end
                ST_LOAD_B: begin
                    r_state <= ST_EXEC;
                    case (r_op)
                        OP_ADD:  r_aAdd <= 1'b1;
                        OP_SUB:  r_aSub <= 1'b1;
                        OP_MUL:  r_aMul <= 1'b1;
                        OP_DIV:  r_aDiv <= 1'b1;
                        OP_CMP:  r_aCmp <= 1'b1;
                        default: ;
                    endcase
                end
                ST_EXEC: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= w_wait_load;
                    r_dp_data  <= '0;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= bus.dp_result;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_accept && !w_gnt_id;
    assign bus.req1_ready = w_accept &&  w_gnt_id;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.dp_data    = r_dp_data;
    assign bus.ldA        = r_ldA;
    assign bus.ldB        = r_ldB;
    assign bus.aCmp       = r_aCmp;
    assign bus.aAdd       = r_aAdd;
    assign bus.aSub       = r_aSub;
    assign bus.aDiv       = r_aDiv;
    assign bus.aMul       = r_aMul;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural datapath model.
// Honours ALU_ARB_DIVZERO_EN for the divide-by-zero expectations.
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    logic clk;
    logic reset;
    int unsigned n_checks;
    int unsigned n_fail;

    alu_req_arbiter_if bus ();

    alu_req_arbiter #(
        .MUL_CYCLES (2),
        .DIV_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: latch operands on the loads, compute on the op strobe
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [7:0] m_res;
    always_ff @(posedge clk) begin
        if (bus.ldA) m_a <= bus.dp_data[7:4];
        if (bus.ldB) m_b <= bus.dp_data[3:0];
        if (bus.aAdd) m_res <= {4'h0, m_a} + {4'h0, m_b};
        if (bus.aSub) m_res <= {4'h0, m_a} - {4'h0, m_b};
        if (bus.aMul) m_res <= {4'h0, m_a} * {4'h0, m_b};
        if (bus.aDiv) m_res <= (m_b == 4'h0) ? 8'hEE : ({4'h0, m_a} / {4'h0, m_b});
        if (bus.aCmp) m_res <= {6'h00, (m_a > m_b), (m_a == m_b)};
    end
    assign bus.dp_result = m_res;

    // Strobe vector order: {ldA, ldB, aCmp, aAdd, aSub, aDiv, aMul}
    function automatic logic [6:0] strobes();
        return {bus.ldA, bus.ldB, bus.aCmp, bus.aAdd, bus.aSub, bus.aDiv, bus.aMul};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One transaction: offer word on requester req, follow it to its response.
    // hold > 0 keeps rsp_ready low that many cycles while the other requester waits.
    task automatic run_op(input string tag, input int unsigned req, input logic [11:0] word,
                          input logic [6:0] exp_exec, input int unsigned exp_lat,
                          input logic [7:0] exp_data, input logic exp_err,
                          input int unsigned hold);
        logic        got;
        logic [6:0]  s;
        logic [6:0]  seq [3];
        logic [11:0] dpd;
        int unsigned nstb;
        int unsigned multi;
        int unsigned lat;
        got   = 1'b0;
        nstb  = 0;
        multi = 0;
        lat   = 0;
        dpd   = '0;
        for (int unsigned k = 0; k < 3; k++) seq[k] = '0;
        bus.rsp_ready = (hold == 0);
        if (req == 0) begin bus.req0_word = word; bus.req0_valid = 1'b1; end
        else          begin bus.req1_word = word; bus.req1_valid = 1'b1; end
        for (int unsigned c = 0; c < 20; c++) begin
            #1;
            got = (req == 0) ? bus.req0_ready : bus.req1_ready;
            if (got) break;
            @(negedge clk);
        end
        chk({tag, "_grant"}, {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!got) return;
        for (int unsigned i = 1; i < 60; i++) begin
            @(negedge clk);
            s = strobes();
            if (i <= 3) seq[i-1] = s;
            if (i == 1) dpd = bus.dp_data;
            if (s != 7'd0) nstb++;
            if ($countones(s) > 1) multi++;
            if (bus.rsp_valid) begin lat = i; break; end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_nstb"}, nstb, (exp_exec != 7'd0) ? 32'd3 : 32'd0);
        chk({tag, "_onehot"}, multi, 32'd0);
        if (exp_exec != 7'd0) begin
            chk({tag, "_ldA"}, {25'd0, seq[0]}, 32'b1000000);
            chk({tag, "_ldB"}, {25'd0, seq[1]}, 32'b0100000);
            chk({tag, "_exec"}, {25'd0, seq[2]}, {25'd0, exp_exec});
            chk({tag, "_dpdata"}, {20'd0, dpd}, {20'd0, word});
        end
        chk({tag, "_id"}, {31'd0, bus.rsp_id}, req);
        chk({tag, "_data"}, {24'd0, bus.rsp_data}, {24'd0, exp_data});
        chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        if (hold > 0) begin
            if (req == 0) begin bus.req1_word = 12'h152; bus.req1_valid = 1'b1; end
            else          begin bus.req0_word = 12'h152; bus.req0_valid = 1'b1; end
            for (int unsigned h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
                chk({tag, "_hold_data"}, {24'd0, bus.rsp_data}, {24'd0, exp_data});
                chk({tag, "_hold_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
                chk({tag, "_hold_id"}, {31'd0, bus.rsp_id}, req);
                chk({tag, "_hold_rdy"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
                chk({tag, "_hold_stb"}, {25'd0, strobes()}, 32'd0);
            end
            bus.rsp_ready  = 1'b1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int unsigned ids [4];
        int unsigned k;
        int unsigned both;
        int unsigned stray;
        logic        rdy;

        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_word  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_word  = '0;
        bus.rsp_ready  = 1'b1;

        // Reset values, with a requester valid to show ready is held off
        @(negedge clk);
        reset          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_word  = 12'h152;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        chk("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        chk("rst_dp_data", {20'd0, bus.dp_data}, 32'd0);
        chk("rst_strobes", {25'd0, strobes()}, 32'd0);
        bus.req0_valid = 1'b0;
        reset          = 1'b1;
        @(negedge clk);

        // Legal ops on both requesters: 5+2, 8/2, 3*5, 9-4, cmp 7==7
        run_op("add", 0, 12'h152, 7'b0001000, 5, 8'h07, 1'b0, 0);
        run_op("div", 1, 12'h482, 7'b0000010, 8, 8'h04, 1'b0, 0);
        run_op("mul", 1, 12'h335, 7'b0000001, 6, 8'h0F, 1'b0, 0);
        run_op("sub", 0, 12'h294, 7'b0000100, 5, 8'h05, 1'b0, 0);
        run_op("cmp", 1, 12'h577, 7'b0010000, 5, 8'h01, 1'b0, 0);

        // Illegal opcode with a stalled consumer
        run_op("ill", 0, 12'hF12, 7'b0000000, 1, 8'h00, 1'b1, 3);

        // Divide by zero
`ifdef ALU_ARB_DIVZERO_EN
        run_op("div0", 1, 12'h460, 7'b0000000, 1, 8'hFF, 1'b1, 0);
`else
        run_op("div0", 1, 12'h460, 7'b0000010, 8, 8'hEE, 1'b0, 0);
`endif

        // Round-robin with both requesters continuously valid
        do_reset();
        bus.rsp_ready  = 1'b1;
        bus.req0_word  = 12'h111;
        bus.req1_word  = 12'h134;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        k    = 0;
        both = 0;
        for (int unsigned c = 0; c < 200 && k < 4; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both++;
            if (bus.req0_ready) begin ids[k] = 0; k++; end
            else if (bus.req1_ready) begin ids[k] = 1; k++; end
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rr_count", k, 32'd4);
        chk("rr_both", both, 32'd0);
        chk("rr_g0", ids[0], 32'd0);
        chk("rr_g1", ids[1], 32'd1);
        chk("rr_g2", ids[2], 32'd0);
        chk("rr_g3", ids[3], 32'd1);
        repeat (15) @(negedge clk);

        // Reset during the WAIT phase of a MUL aborts it silently
        bus.req0_word  = 12'h323;
        bus.req0_valid = 1'b1;
        rdy = 1'b0;
        for (int unsigned c = 0; c < 20; c++) begin
            #1;
            rdy = bus.req0_ready;
            if (rdy) break;
            @(negedge clk);
        end
        chk("abort_grant", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_strobes", {25'd0, strobes()}, 32'd0);
        chk("abort_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        bus.req1_word  = 12'h152;
        bus.req1_valid = 1'b1;
        #1;
        chk("abort_idle", {31'd0, bus.req1_ready}, 32'd1);
        bus.req1_valid = 1'b0;
        stray = 0;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray++;
        end
        chk("abort_no_rsp", stray, 32'd0);
        run_op("post", 1, 12'h1A3, 7'b0001000, 5, 8'h0D, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
